// File: rtl/mips_wb_trace_buffer.sv
// mips_wb_trace_buffer: write-back trace capture for the MIPS16 pipeline.
// Snoops the WB register-file write port plus the retiring PC into a
// circular buffer. Capture starts at arm, or at a trigger write. It ends on
// stop, or when the buffer fills and wrap is off. After capture ends, the
// buffer unloads oldest-first.
//
// Optional feature macro: TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp to
// each entry and an rd_ts output.
//
// Read handshake: rd_valid/rd_dest/rd_data/rd_pc are presented from registered
// state and stay stable while rd_valid=1 and rd_ready=0. An entry transfers
// on a rising edge where rd_valid=1 and rd_ready=1. rd_ready has no effect
// while rd_valid=0. rd_valid never depends on rd_ready.
module mips_wb_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wrap,
  input  logic              cfg_trig_en,
  input  logic [2:0]        cfg_trig_dest,
  input  logic              arm,
  input  logic              stop,
  input  logic              wb_en,
  input  logic [2:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [PC_W-1:0]   wb_pc,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [2:0]        rd_dest,
  output logic [DATA_W-1:0] rd_data,
  output logic [PC_W-1:0]   rd_pc,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [1:0]        state_o
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [15:0]       rd_ts
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0]        dest;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]       ts;
`endif
  } entry_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   FULL    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   FULL_M1 = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wrap_q;
  logic [2:0]        trig_dest_q;
  entry_t            mem [DEPTH];
  entry_t            wr_entry;
  entry_t            rd_entry;
  logic              trig_hit;
  logic              capture_we;

  // The trigger-enable mode is not stored separately; it is encoded by
  // entering ARMED instead of CAPTURE at arm time.
  assign trig_hit   = wb_en && (wb_dest == trig_dest_q);
  assign capture_we = !arm && wb_en &&
                      ((state == CAPTURE) || ((state == ARMED) && trig_hit));

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_cnt;

  // Free-running cycle stamp, restarted by arm so that stamps are relative to
  // the session start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt <= 16'd0;
    end else if (arm) begin
      ts_cnt <= 16'd0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
    end
  end
`endif

  // Assemble the entry that is written on a captured write-back.
  always_comb begin
    wr_entry      = '0;
    wr_entry.dest = wb_dest;
    wr_entry.data = wb_data;
    wr_entry.pc   = wb_pc;
`ifdef TRACE_TIMESTAMP_EN
    wr_entry.ts   = ts_cnt;
`endif
  end

  // Trace storage. It has no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (capture_we) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Session control: arm/stop/trigger sequencing, pointers, count, overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      wrap_q      <= 1'b0;
      trig_dest_q <= 3'd0;
    end else if (arm) begin
      // arm wins over stop and wb_en in the same cycle.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      wrap_q      <= cfg_wrap;
      trig_dest_q <= cfg_trig_dest;
      state       <= cfg_trig_en ? ARMED : CAPTURE;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        ARMED: begin
          if (trig_hit) begin
            // DEPTH >= 2, so the trigger entry alone never fills the buffer.
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count + CNT_ONE;
            state  <= stop ? DONE : CAPTURE;
          end else if (stop) begin
            state <= DONE;
          end
        end
        CAPTURE: begin
          if (wb_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (count != FULL) begin
              count <= count + CNT_ONE;
              if (!wrap_q && (count == FULL_M1)) begin
                state <= DONE;
              end
            end else if (wrap_q) begin
              // Full and wrapping: the new entry replaces the oldest one.
              rd_ptr   <= rd_ptr + PTR_ONE;
              overflow <= 1'b1;
            end
          end
          if (stop) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (rd_valid && rd_ready) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            count  <= count - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Show-ahead read port. The fields are zeroed whenever nothing is presented.
  assign rd_entry = mem[rd_ptr];
  assign rd_valid = (state == DONE) && (count != '0);
  assign rd_dest  = rd_valid ? rd_entry.dest : 3'd0;
  assign rd_data  = rd_valid ? rd_entry.data : '0;
  assign rd_pc    = rd_valid ? rd_entry.pc   : '0;
`ifdef TRACE_TIMESTAMP_EN
  assign rd_ts    = rd_valid ? rd_entry.ts   : 16'd0;
`endif
  assign state_o  = state;

endmodule

// File: tb/tb_mips_wb_trace_buffer.sv
// Directed testbench for mips_wb_trace_buffer with the default parameters
// (DATA_W=16, PC_W=8, DEPTH=16). Inputs change 1 time unit after a rising
// edge, and outputs are checked there as well.
module tb_mips_wb_trace_buffer;

  logic        clk;
  logic        rst;
  logic        cfg_wrap;
  logic        cfg_trig_en;
  logic [2:0]  cfg_trig_dest;
  logic        arm;
  logic        stop;
  logic        wb_en;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic [7:0]  wb_pc;
  logic        rd_ready;
  logic        rd_valid;
  logic [2:0]  rd_dest;
  logic [15:0] rd_data;
  logic [7:0]  rd_pc;
  logic [4:0]  count;
  logic        overflow;
  logic [1:0]  state_o;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] rd_ts;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  mips_wb_trace_buffer #(.DATA_W(16), .PC_W(8), .DEPTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_wrap      (cfg_wrap),
    .cfg_trig_en   (cfg_trig_en),
    .cfg_trig_dest (cfg_trig_dest),
    .arm           (arm),
    .stop          (stop),
    .wb_en         (wb_en),
    .wb_dest       (wb_dest),
    .wb_data       (wb_data),
    .wb_pc         (wb_pc),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_dest       (rd_dest),
    .rd_data       (rd_data),
    .rd_pc         (rd_pc),
    .count         (count),
    .overflow      (overflow),
    .state_o       (state_o)
`ifdef TRACE_TIMESTAMP_EN
    ,
    .rd_ts         (rd_ts)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic w, input logic te, input logic [2:0] td);
    cfg_wrap      = w;
    cfg_trig_en   = te;
    cfg_trig_dest = td;
    arm           = 1'b1;
    step();
    arm           = 1'b0;
  endtask

  // One write-back event; the PC is the low byte of the data.
  task automatic wb(input logic [2:0] d, input logic [15:0] v);
    wb_en   = 1'b1;
    wb_dest = d;
    wb_data = v;
    wb_pc   = v[7:0];
    step();
    wb_en   = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Scoreboard: pop every expected entry with rd_ready=1, then expect empty.
  task automatic unload(input string tag);
    logic [15:0] e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, rd_valid, 1);
      check({tag, "_data"}, rd_data, e);
      check({tag, "_pc"}, rd_pc, e[7:0]);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    check({tag, "_empty_valid"}, rd_valid, 0);
    check({tag, "_empty_count"}, count, 0);
    check({tag, "_empty_data"}, rd_data, 0);
  endtask

  initial begin
    rst = 1'b0; cfg_wrap = 1'b0; cfg_trig_en = 1'b0; cfg_trig_dest = 3'd0;
    arm = 1'b0; stop = 1'b0; wb_en = 1'b0; wb_dest = 3'd0; wb_data = 16'd0;
    wb_pc = 8'd0; rd_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("por_state", state_o, 0);
    check("por_count", count, 0);

    // 1. Asynchronous reset in the middle of a capture session
    do_arm(1'b0, 1'b0, 3'd0);
    for (int i = 1; i <= 5; i++) wb(3'd1, 16'(i));
    check("t1_cap_state", state_o, 2);
    check("t1_cap_count", count, 5);
    #2 rst = 1'b0;
    #1;
    check("t1_async_state", state_o, 0);
    check("t1_async_count", count, 0);
    step();
    rst = 1'b1;
    step();
    check("t1_state", state_o, 0);
    check("t1_count", count, 0);
    check("t1_overflow", overflow, 0);
    check("t1_valid", rd_valid, 0);
    check("t1_data", rd_data, 0);
    check("t1_dest", rd_dest, 0);
    check("t1_pc", rd_pc, 0);
`ifdef TRACE_TIMESTAMP_EN
    check("t1_ts", rd_ts, 0);
`endif
    wb(3'd1, 16'h9999);
    check("t1_idle_wb_count", count, 0);
    check("t1_idle_wb_state", state_o, 0);

    // 2. Stop when full: 16 events fill the buffer and end the capture
    do_arm(1'b0, 1'b0, 3'd0);
    check("t2_armed_state", state_o, 2);
    for (int i = 1; i <= 16; i++) begin
      wb(3'd2, 16'(i));
      exp_q.push_back(16'(i));
    end
    check("t2_full_state", state_o, 3);
    check("t2_full_count", count, 16);
    for (int i = 17; i <= 20; i++) wb(3'd2, 16'(i));
    check("t2_count_after_extra", count, 16);
    check("t2_overflow", overflow, 0);
    check("t2_first_dest", rd_dest, 2);
    unload("t2");

    // 3. Wrap mode: 20 events keep the newest 16 entries
    do_arm(1'b1, 1'b0, 3'd0);
    for (int i = 1; i <= 20; i++) wb(3'd3, 16'(i));
    check("t3_cap_state", state_o, 2);
    do_stop();
    check("t3_state", state_o, 3);
    check("t3_count", count, 16);
    check("t3_overflow", overflow, 1);
    for (int i = 5; i <= 20; i++) exp_q.push_back(16'(i));
    unload("t3");

    // 4. Trigger on r5
    do_arm(1'b0, 1'b1, 3'd5);
    check("t4_armed_state", state_o, 1);
    wb(3'd3, 16'hAAAA);
    check("t4_pre_trig_state", state_o, 1);
    check("t4_pre_trig_count", count, 0);
    check("t4_armed_valid", rd_valid, 0);
    wb(3'd5, 16'hBBBB);
    check("t4_trig_state", state_o, 2);
    wb(3'd2, 16'hCCCC);
    do_stop();
    check("t4_count", count, 2);
    check("t4_e0_dest", rd_dest, 5);
    check("t4_e0_data", rd_data, 16'hBBBB);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("t4_e1_dest", rd_dest, 2);
    check("t4_e1_data", rd_data, 16'hCCCC);
    check("t4_e1_pc", rd_pc, 8'hCC);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("t4_empty", rd_valid, 0);

    // 4b. Stop while armed, with and without a coincident trigger hit
    do_arm(1'b0, 1'b1, 3'd4);
    do_stop();
    check("t4b_stop_state", state_o, 3);
    check("t4b_stop_count", count, 0);
    check("t4b_stop_valid", rd_valid, 0);
    do_arm(1'b0, 1'b1, 3'd4);
    stop = 1'b1;
    wb(3'd4, 16'h0777);
    stop = 1'b0;
    check("t4b_hit_state", state_o, 3);
    check("t4b_hit_count", count, 1);
    exp_q.push_back(16'h0777);
    unload("t4b");

    // 5. Stop coincident with a write, then unload with back-pressure
    do_arm(1'b0, 1'b0, 3'd0);
    for (int i = 1; i <= 3; i++) wb(3'd1, 16'(i));
    stop = 1'b1;
    wb(3'd1, 16'h1234);
    stop = 1'b0;
    check("t5_state", state_o, 3);
    check("t5_count", count, 4);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h1234);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      rd_ready = 1'b0;
      step();
      check("t5_hold_valid", rd_valid, 1);
      check("t5_hold_data", rd_data, e);
      check("t5_hold_dest", rd_dest, 1);
      rd_ready = 1'b1;
      step();
    end
    rd_ready = 1'b0;
    check("t5_empty", rd_valid, 0);
    check("t5_empty_count", count, 0);

    // 6. Re-arm from DONE; a write in the arm cycle is not captured
    do_arm(1'b0, 1'b0, 3'd0);
    for (int i = 1; i <= 7; i++) wb(3'd6, 16'(i));
    do_stop();
    check("t6_done_count", count, 7);
    check("t6_done_valid", rd_valid, 1);
    wb_en = 1'b1; wb_dest = 3'd1; wb_data = 16'h5555; wb_pc = 8'h55;
    do_arm(1'b0, 1'b0, 3'd0);
    wb_en = 1'b0;
    check("t6_rearm_count", count, 0);
    check("t6_rearm_valid", rd_valid, 0);
    check("t6_rearm_state", state_o, 2);
    do_stop();
    check("t6_stop_count", count, 0);
    check("t6_stop_valid", rd_valid, 0);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("t6_ready_idle_count", count, 0);
    check("t6_ready_idle_state", state_o, 3);

`ifdef TRACE_TIMESTAMP_EN
    // Timestamps: the stamp is cleared at the arm edge and counts each edge
    do_arm(1'b0, 1'b0, 3'd0);
    step();
    step();
    wb(3'd1, 16'h00A1);
    step();
    step();
    wb(3'd1, 16'h00A2);
    do_stop();
    check("ts_e0", rd_ts, 2);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("ts_e1", rd_ts, 5);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("ts_empty", rd_ts, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_wb_trace_buffer.md
Name: mips_wb_trace_buffer

Overview:
- Parametrised write-back trace capture block for the MIPS16 pipeline.
- Snoops the WB-stage register-file write port (enable, destination, data) and the associated PC.
- Records events into a circular on-chip buffer with optional trigger, wrap/stop modes and overflow flag.
- After capture stops, unloads entries oldest-first over a valid/ready port. Used by the bench and by debug logic to reconstruct retired-instruction history.

Parameters:
DATA_W, 16, width of captured write-back data
PC_W, 8, width of captured PC (matches PC_WIDTH)
DEPTH, 16, number of trace entries; power of 2, >= 2
ADDR_W, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
cfg_wrap  input  1  0: stop when full; 1: circular overwrite of oldest entry
cfg_trig_en  input  1  0: capture starts at arm; 1: capture starts at trigger write
cfg_trig_dest  input  3  trigger register number
arm  input  1  single-cycle pulse: clear buffer, sample cfg_*, start session
stop  input  1  single-cycle pulse: end capture
wb_en  input  1  write-back event valid (reg_write_en)
wb_dest  input  3  write-back destination (reg_write_dest)
wb_data  input  DATA_W  write-back data (reg_write_data)
wb_pc  input  PC_W  PC of the retiring instruction
rd_ready  input  1  consumer accepts the current entry
rd_valid  output  1  entry presented on rd_*
rd_dest  output  3  entry destination
rd_data  output  DATA_W  entry data
rd_pc  output  PC_W  entry PC
count  output  ADDR_W+1  entries held, 0..DEPTH
overflow  output  1  sticky: at least one entry overwritten this session
state_o  output  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

Behaviour:
- Reset (rst=0, async): state IDLE; wr_ptr, rd_ptr, count = 0; overflow = 0; rd_valid = 0. Trace array is not reset.
- rd_dest, rd_data and rd_pc are forced to 0 whenever rd_valid=0.
- Reset mid-session discards all contents.
- arm, in any state:
  - clears pointers, count and overflow;
  - latches cfg_wrap, cfg_trig_en, cfg_trig_dest (cfg_* ignored otherwise);
  - next state ARMED if cfg_trig_en=1, else CAPTURE;
  - arm has priority over stop and wb_en in the same cycle (that wb event is not captured).
- IDLE: wb_en ignored; stop ignored.
- ARMED:
  - wb_en && wb_dest==trig_dest: event written as entry 0; next state CAPTURE.
  - stop: DONE with count=0. Also DONE if stop coincides with a trigger hit, in which case the trigger entry is kept.
- CAPTURE, each wb_en cycle:
  - write {dest,data,pc} at wr_ptr; wr_ptr++ mod DEPTH.
  - count < DEPTH: count++.
  - count == DEPTH and wrap=1: overwrite oldest; rd_ptr++; count stays DEPTH; overflow=1.
  - wrap=0 and the write makes count==DEPTH: next state DONE (write latency 1 cycle).
  - stop: next state DONE; a simultaneous wb_en is still captured.
- DONE:
  - wb_en ignored; rd_valid = (count != 0).
  - rd_* show-ahead from array[rd_ptr], combinational from registered state.
  - rd_valid && rd_ready: pop, rd_ptr++ mod DEPTH, count--.
  - rd_ready with rd_valid=0 has no effect; stays in DONE until arm.
- rd_valid is 0 in IDLE, ARMED and CAPTURE.
- Pointers wrap modulo DEPTH with no bubble.

Optional Feature:
Macro TRACE_TIMESTAMP_EN.
- Defined:
  - 16-bit cycle counter, cleared by reset and arm, +1 every clk, wraps 0xFFFF->0;
  - stored with each entry;
  - extra output rd_ts [15:0], forced to 0 when rd_valid=0.
- Undefined: no counter, no rd_ts port, narrower entry; all other behaviour identical.

Test Plan:
1. Reset: hold rst=0 mid-CAPTURE with 5 entries; release -> state_o=0, count=0, overflow=0, rd_valid=0, rd_*=0.
2. DEPTH=16, wrap=0, trig_en=0, arm; 20 wb_en events data 0x0001..0x0014 -> state DONE one cycle after 16th, count=16, overflow=0. Unload with rd_ready=1 -> data 0x0001..0x0010 in order, then rd_valid=0.
3. wrap=1, trig_en=0, arm; 20 events 0x0001..0x0014, stop -> count=16, overflow=1, unload 0x0005..0x0014.
4. trig_en=1, trig_dest=5; writes r3=0xAAAA, r5=0xBBBB, r2=0xCCCC, stop -> count=2, entries (5,0xBBBB),(2,0xCCCC).
5. stop coincident with wb_en(r1=0x1234) after 3 events -> count=4, last entry 0x1234. Unload with rd_ready toggling 1,0,1,0 -> each entry held stable until accepted.
6. arm during DONE with count=7 -> count=0, rd_valid=0 next cycle; wb in same cycle as arm not captured. With TRACE_TIMESTAMP_EN: events on cycles 2,5 after arm -> rd_ts 2, 5.
